// File: rtl/apb_cmd_bridge_pkg.sv
// Shared types and helpers for the CPU-to-APB command bridge.
package apb_cmd_bridge_pkg;

  // APB master phases: IDLE (no transfer), SETUP (PSEL only), ACCESS (PSEL+PENABLE).
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Width of a slave index; a single slave still gets a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_cmd_bridge_cmd_fifo.sv
// Synchronous FIFO of generic entries; DEPTH must be a power of two so the
// pointers wrap naturally.
module apb_cmd_bridge_cmd_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  T            din,
  input  logic        pop,
  output T            dout,
  output logic        full,
  output logic        empty,
  output logic [PW:0] level
);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; push while full and pop while empty are ignored.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  // Control state, cleared by reset (which also flushes the contents logically).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/apb_cmd_bridge.sv
// CPU-to-APB3 master bridge: buffers read/write commands, issues them to one
// of NSLV slaves and returns exactly one in-order response per command.
// Handshakes: a CPU command transfers on a rising edge where cpu_valid and
// cpu_ready are both high; rsp_valid is a one-cycle pulse with no ready.
module apb_cmd_bridge
  import apb_cmd_bridge_pkg::*;
#(
  parameter int  AW      = 32,
  parameter int  DW      = 32,
  parameter int  NSLV    = 4,
  parameter int  DEPTH   = 4,
  parameter int  TIMEOUT = 16,
  localparam int SW      = sel_width(NSLV),
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_valid,
  output logic             cpu_ready,
  input  logic             cpu_write,
  input  logic [SW-1:0]    cpu_sel,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  output logic [LW-1:0]    fifo_level,
  output logic             rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic [NSLV-1:0]  PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [AW-1:0]    PADDR,
  output logic [DW-1:0]    PWDATA,
  input  logic [NSLV*DW-1:0] PRDATA,
  input  logic [NSLV-1:0]  PREADY,
  input  logic [NSLV-1:0]  PSLVERR,
  output apb_state_e       dbg_state
);

  localparam int NP  = 1 << SW;
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic          write;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  cmd_t       push_cmd, head;
  logic       fifo_full, fifo_empty, fifo_pop;
  logic [NP-1:0] legal_mask;
  logic       head_legal, start_xfer;
  logic       pready_sel, pslverr_sel;
  logic [DW-1:0] prdata_sel;

  apb_state_e    state_q, state_d;
  logic [NSLV-1:0] psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

  assign push_cmd  = '{write: cpu_write, sel: cpu_sel, addr: cpu_addr, wdata: cpu_wdata};
  assign cpu_ready = !fifo_full;

  apb_cmd_bridge_cmd_fifo #(.T(cmd_t), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cpu_valid),
    .din   (push_cmd),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Select codes at or above NSLV address no slave and are answered with an error.
  always_comb begin
    for (int i = 0; i < NP; i++) legal_mask[i] = (i < NSLV);
    head_legal = legal_mask[head.sel];
  end

  // Route the active slave's ready/error/data back to the state machine.
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q == SW'(i)) begin
        pready_sel  = PREADY[i];
        pslverr_sel = PSLVERR[i];
        prdata_sel  = PRDATA[i*DW +: DW];
      end
    end
  end

  // Next-state logic: IDLE/SETUP/ACCESS sequencing, timeout and response build.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    sel_d       = sel_q;
    tcnt_d      = tcnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    fifo_pop    = 1'b0;
    start_xfer  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head_legal) begin
            start_xfer = 1'b1;
          end else begin
            fifo_pop    = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (pready_sel) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_sel;
          if (!pwrite_q && !pslverr_sel) rsp_rdata_d = prdata_sel;
          if (!fifo_empty && head_legal) begin
            start_xfer = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            psel_d    = '0;
            penable_d = 1'b0;
          end
        end else if ((TIMEOUT != 0) && (tcnt_q == TCW'(TIMEOUT - 1))) begin
          state_d     = ST_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new transfer pops the head and enters SETUP with the address phase loaded.
    if (start_xfer) begin
      fifo_pop  = 1'b1;
      state_d   = ST_SETUP;
      psel_d    = NSLV'(1) << head.sel;
      penable_d = 1'b0;
      pwrite_d  = head.write;
      paddr_d   = head.addr;
      pwdata_d  = head.wdata;
      sel_d     = head.sel;
      tcnt_d    = '0;
    end
  end

  // State machine registers; every APB and response output comes from here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      sel_q       <= '0;
      tcnt_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      sel_q       <= sel_d;
      tcnt_q      <= tcnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_cmd_bridge.sv
// Bench for apb_cmd_bridge with three slaves (select 3 is illegal), a
// scripted per-transfer slave model and an in-order response scoreboard.
module tb_apb_cmd_bridge;
  import apb_cmd_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NSLV = 3;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 16;
  localparam int SW = 2;
  localparam int LW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              cpu_valid, cpu_ready, cpu_write;
  logic [SW-1:0]     cpu_sel;
  logic [AW-1:0]     cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic [LW-1:0]     fifo_level;
  logic              rsp_valid, rsp_err;
  logic [DW-1:0]     rsp_rdata;
  logic [NSLV-1:0]   PSEL, PREADY, PSLVERR;
  logic              PENABLE, PWRITE;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic [NSLV*DW-1:0] PRDATA;
  apb_state_e        dbg_state;

  apb_cmd_bridge #(.AW(AW), .DW(DW), .NSLV(NSLV), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_write(cpu_write),
    .cpu_sel(cpu_sel), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .fifo_level(fifo_level),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic          write;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            wait_cyc;
    logic          err;
    logic [DW-1:0] rdata;
  } xfer_t;

  logic [DW:0] exp_q[$];     // {err, rdata} per command, in command order
  xfer_t       slv_q[$];     // transfers the APB side should see, in order
  int          rsp_cyc_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          hs_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Reference: outcome of a command from its select, direction and slave behaviour.
  function automatic logic [DW:0] model_rsp(input xfer_t x);
    logic e;
    if (int'(x.sel) >= NSLV) return {1'b1, {DW{1'b0}}};
    e = x.err || (x.wait_cyc >= TIMEOUT);
    return {e, (!x.write && !e) ? x.rdata : {DW{1'b0}}};
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send(input logic w, input logic [SW-1:0] sel, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input int wt, input logic err,
                      input logic [DW-1:0] rd);
    xfer_t x;
    int n;
    x = '{write: w, sel: sel, addr: addr, wdata: wdata, wait_cyc: wt, err: err, rdata: rd};
    cpu_valid = 1'b1; cpu_write = w; cpu_sel = sel; cpu_addr = addr; cpu_wdata = wdata;
    n = 0;
    while (!cpu_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_ready) begin
      fail_now("cpu_ready_stall", "cpu_ready stayed 0 for 300 cycles");
      cpu_valid = 1'b0;
      return;
    end
    exp_q.push_back(model_rsp(x));
    if (int'(sel) < NSLV) slv_q.push_back(x);
    @(negedge clk);
    hs_cyc = cyc;
    cpu_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout", $sformatf("%0d responses missing", exp_q.size()));
    repeat (2) @(negedge clk);
  endtask

  // ---------------- slave model ----------------
  xfer_t s_cur;
  logic  s_active = 1'b0;
  int    s_acc = 0;

  // Each transfer is ready on ACCESS cycle index wait_cyc; other slaves babble randomly.
  always @(negedge clk) begin
    if (!rst_n) begin
      s_active = 1'b0;
      PREADY = '0;
      PSLVERR = '0;
    end else begin
      if (s_active && !(PSEL != 0 && PENABLE)) begin
        if (s_cur.wait_cyc >= TIMEOUT) begin
          check("timeout_access_cycles", 64'(s_acc), 64'(TIMEOUT));
          check("abort_psel_penable", {PSEL, PENABLE}, 64'd0);
        end else begin
          check("access_cycles", 64'(s_acc), 64'(s_cur.wait_cyc + 1));
        end
        s_active = 1'b0;
      end
      for (int i = 0; i < NSLV; i++) PRDATA[i*DW +: DW] = $urandom;
      PREADY  = NSLV'($urandom);
      PSLVERR = NSLV'($urandom);
      if (PSEL != 0 && !PENABLE) begin
        if (slv_q.size() == 0) begin
          fail_now("unexpected_setup", $sformatf("PSEL=%b with no transfer pending", PSEL));
        end else begin
          s_cur = slv_q.pop_front();
          s_active = 1'b1;
          s_acc = 0;
          check("setup_psel", 64'(PSEL), 64'(3'b001 << s_cur.sel));
          check("setup_paddr", 64'(PADDR), 64'(s_cur.addr));
          check("setup_pwrite", 64'(PWRITE), 64'(s_cur.write));
          if (s_cur.write) check("setup_pwdata", 64'(PWDATA), 64'(s_cur.wdata));
        end
      end else if (PSEL != 0 || PENABLE) begin
        if (!s_active) begin
          fail_now("stray_access", $sformatf("PSEL=%b PENABLE=%b outside a transfer", PSEL, PENABLE));
        end else begin
          check("hold_psel_paddr_pwrite", {PSEL, PADDR, PWRITE},
                {3'b001 << s_cur.sel, s_cur.addr, s_cur.write});
          if (s_cur.write) check("hold_pwdata", 64'(PWDATA), 64'(s_cur.wdata));
          PREADY[s_cur.sel]  = (s_acc == s_cur.wait_cyc);
          PSLVERR[s_cur.sel] = (s_acc == s_cur.wait_cyc) && s_cur.err;
          PRDATA[s_cur.sel*DW +: DW] = s_cur.rdata;
          s_acc++;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_rsp", $sformatf("rsp_valid=1 err=%b rdata=%h, none expected", rsp_err, rsp_rdata));
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", 64'(rsp_err), 64'(e[DW]));
        check("rsp_rdata", 64'(rsp_rdata), 64'(e[DW-1:0]));
      end
      rsp_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic w;
    int wt, pick;
    cpu_valid = 0; cpu_write = 0; cpu_sel = 0; cpu_addr = 0; cpu_wdata = 0;
    PRDATA = '0; PREADY = '0; PSLVERR = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 64'd0);
    check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    check("reset_fifo", {fifo_level, cpu_ready}, {3'd0, 1'b1});
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait write: response three edges after the handshake edge.
    send(1'b1, 2'd1, 32'h10, 32'hA5A5_0001, 0, 1'b0, 32'h0);
    drain();
    check("t1_latency", 64'(rsp_cyc_q[rsp_cyc_q.size()-1] - hs_cyc), 64'd3);

    // Read with three wait states.
    send(1'b0, 2'd2, 32'h24, 32'h0, 3, 1'b0, 32'hDEAD_BEEF);
    drain();

    // FIFO fills behind a slow transfer, then drains back-to-back.
    send(1'b1, 2'd1, 32'h100, 32'h1111_0000, 12, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++)
      send(k[0], 2'(k % 3), 32'h200 + 32'(k * 4), 32'h2222_0000 + 32'(k), 0, 1'b0, 32'h3333_0000 + 32'(k));
    check("t3_full_level", 64'(fifo_level), 64'd4);
    check("t3_full_ready", 64'(cpu_ready), 64'd0);
    send(1'b0, 2'd0, 32'h300, 32'h0, 0, 1'b0, 32'h4444_4444);
    drain();
    for (int k = rsp_cyc_q.size() - 5; k < rsp_cyc_q.size(); k++)
      check("t3_back_to_back", 64'(rsp_cyc_q[k] - rsp_cyc_q[k-1]), 64'd2);

    // Slave error on a read, then a normal read.
    send(1'b0, 2'd0, 32'h40, 32'h0, 0, 1'b1, 32'hBAD0_BAD0);
    send(1'b0, 2'd0, 32'h44, 32'h0, 1, 1'b0, 32'h1234_5678);
    drain();

    // Timeout boundary (15 completes, 16 aborts) and an illegal select.
    send(1'b0, 2'd1, 32'h50, 32'h0, 15, 1'b0, 32'hCAFE_0015);
    send(1'b1, 2'd2, 32'h54, 32'h5555_0000, 1000, 1'b0, 32'h0);
    send(1'b0, 2'd3, 32'h58, 32'h0, 0, 1'b0, 32'h0);
    send(1'b1, 2'd0, 32'h5C, 32'h6666_0000, 0, 1'b0, 32'h0);
    drain();

    // Reset during ACCESS drops everything.
    send(1'b0, 2'd0, 32'h60, 32'h0, 10, 1'b0, 32'h7777_7777);
    send(1'b1, 2'd1, 32'h64, 32'h8888_8888, 0, 1'b0, 32'h0);
    n = 0;
    while (!PENABLE && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_access", 64'(PENABLE), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 64'd0);
    check("t6_async_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    check("t6_async_fifo", {fifo_level, cpu_ready}, {3'd0, 1'b1});
    exp_q.delete();
    slv_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t6_level_after", 64'(fifo_level), 64'd0);
    send(1'b0, 2'd2, 32'h68, 32'h0, 2, 1'b0, 32'h9999_0001);
    drain();

    // Randomised traffic.
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pick = $urandom_range(0, 9);
      wt = (pick < 6) ? $urandom_range(0, 3) : (pick == 6) ? 15 : (pick == 7) ? 16 : (pick == 8) ? 20 : 0;
      w = 1'($urandom);
      send(w, 2'($urandom_range(0, 3)), $urandom, $urandom, wt, ($urandom_range(0, 7) == 0), $urandom);
    end
    drain();
    check("final_level", 64'(fifo_level), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
